// File: rtl/mac_sat_fifo.sv
// Saturating FIFO behind a wide accumulator: narrows each accepted value to width_p bits.
// Optional round-half-up of frac_p fraction bits before saturation: define MAC_SAT_FIFO_ROUND_EN.
`timescale 1ns/1ps

module mac_sat_fifo #(
  parameter int width_p      = 10,
  parameter int depth_log2_p = 2,
  parameter int frac_p       = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [2*width_p-1:0]    data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    ready_i,
  input  logic                    clear_i,
  output logic                    sat_o,
  output logic [depth_log2_p:0]   count_o
);

  localparam int                    depth_lp = 1 << depth_log2_p;
  localparam logic [depth_log2_p:0] depth_c  = (depth_log2_p+1)'(depth_lp);

  logic [width_p-1:0]      mem [depth_lp];
  logic [depth_log2_p-1:0] wr_ptr, rd_ptr;
  logic [depth_log2_p:0]   count_q;
  logic                    sat_q;

  logic                    push, pop;
  logic                    over;
  logic [width_p-1:0]      low_bits;
  logic [width_p-1:0]      store_val;

`ifdef MAC_SAT_FIFO_ROUND_EN
  // One extra bit keeps the rounding add from wrapping at the top of the input range.
  localparam logic [2*width_p:0] half_c = (2*width_p+1)'(1) << (frac_p - 1);
  logic [2*width_p:0] rounded;

  assign rounded  = ({1'b0, data_i} + half_c) >> frac_p;
  assign over     = |rounded[2*width_p:width_p];
  assign low_bits = rounded[width_p-1:0];
`else
  assign over     = |data_i[2*width_p-1:width_p];
  assign low_bits = data_i[width_p-1:0];
`endif

  assign store_val = over ? '1 : low_bits;

  assign ready_o = (count_q != depth_c);
  assign valid_o = (count_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign count_o = count_q;
  assign sat_o   = sat_q;
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

  // NOTE: storage carries no reset; it is only ever observed through valid_o, so stale contents stay hidden.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem[wr_ptr] <= store_val;
  end

  // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (over) sat_q <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/mac_sat_fifo.md
MAC_SAT_FIFO -- requirements
Module: mac_sat_fifo

Interface
REQ-001 SHALL have parameter width_p, default 10, output data width; the input is 2*width_p bits wide, matching the accumulator stage upstream.
REQ-002 SHALL have parameter depth_log2_p, default 2, giving a FIFO depth of 2**depth_log2_p entries (4 by default).
REQ-003 SHALL have parameter frac_p, default 5, giving the fraction bits dropped when rounding is compiled in.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 data_i  input  2*width_p  upstream accumulator value.
REQ-007 valid_i  input  1  upstream data valid.
REQ-008 ready_o  output  1  block can accept an entry.
REQ-009 valid_o  output  1  head entry available.
REQ-010 data_o  output  width_p  head entry, saturated to width_p bits.
REQ-011 ready_i  input  1  downstream accepts the head entry.
REQ-012 clear_i  input  1  synchronous flush of the FIFO and clear of the sticky flag.
REQ-013 sat_o  output  1  sticky flag: at least one accepted value saturated since reset or clear.
REQ-014 count_o  output  depth_log2_p+1  number of entries currently held.

Function
REQ-015 SHALL accept an entry only when valid_i & ready_o are high at a clock edge (push), and SHALL release one only when valid_o & ready_i are high (pop).
REQ-016 ready_o SHALL equal (count_o != depth); it SHALL NOT depend combinationally on ready_i, so there is no push-through when full.
REQ-017 valid_o SHALL equal (count_o != 0); data_o SHALL be the head entry when valid_o=1, and 0 when valid_o=0.
REQ-018 Latency: a value pushed at edge N SHALL appear on data_o with valid_o=1 after edge N when the FIFO was empty; there is no combinational path from data_i to data_o.
REQ-019 Saturation: if the stored value exceeds 2**width_p-1, the block SHALL store 2**width_p-1 and SHALL set sat_o at the same edge; otherwise it stores the value's low width_p bits.
REQ-020 Ordering SHALL be strict FIFO; the read and write pointers SHALL be depth_log2_p bits and wrap modulo the depth.
REQ-021 Simultaneous push and pop SHALL leave count_o unchanged and SHALL be legal at any count from 1 to depth-1; at count 0, only the push takes effect, because valid_o=0.
REQ-022 count_o SHALL increment on push-only, decrement on pop-only, and hold otherwise; it SHALL never exceed the depth or go below 0.
REQ-023 clear_i=1 SHALL, at the next edge, set count_o to 0, both pointers to 0, and sat_o to 0, with priority over any concurrent push or pop; that push is dropped.
REQ-024 sat_o, once set, SHALL hold until clear_i or reset, independent of pops.

Reset
REQ-025 While reset_ni=0, the block SHALL immediately (asynchronously) force count_o=0, pointers=0, sat_o=0, valid_o=0, data_o=0, and ready_o=1.
REQ-026 Reset asserted mid-operation SHALL discard all held entries; the first push after deassertion SHALL be treated as into an empty FIFO.
REQ-027 Storage array contents need no reset; data_o masking under REQ-017 SHALL hide them.

Configuration
REQ-028 With macro MAC_SAT_FIFO_ROUND_EN defined, the stored value SHALL be (data_i + 2**(frac_p-1)) >> frac_p, computed at 2*width_p+1 bits so the add cannot overflow, then saturated per REQ-019.
REQ-029 Without MAC_SAT_FIFO_ROUND_EN, the stored value SHALL be data_i saturated per REQ-019, and frac_p SHALL be unused.

Verification (width_p=10, depth 4, frac_p=5)
REQ-030 Assert reset_ni=0 mid-stream with count 3 -> immediately valid_o=0, ready_o=1, count_o=0, sat_o=0, data_o=0.
REQ-031 No macro, ready_i=1: push 5, 1023, 1024 -> data_o gives 5, 1023, 1023 in order; sat_o rises after the edge that accepts 1024 and stays high.
REQ-032 ready_i=0: push 7, 8, 9, 10 -> count_o=4, ready_o=0; a held valid_i with 11 is not accepted; one pop -> ready_o=1, and 11 is then accepted; the full drain order is 8, 9, 10, 11 (wrap exercised).
REQ-033 At count 2: push and pop in the same cycle for 6 cycles -> count_o stays 2 and no reordering occurs.
REQ-034 At count 3, sat_o=1, assert clear_i with a concurrent push of 3 -> next cycle count_o=0, valid_o=0, sat_o=0, and 3 never appears.
REQ-035 With MAC_SAT_FIFO_ROUND_EN: push 47, 48, 0xFFFFF -> data_o gives 1, 2, 1023; sat_o is set only by the third.
